// File: rtl/rsa32_pkg.sv
// ---------------------------------------------------------------------------
// rsa32_pkg
// Shared definitions for the rsa32 host-side sequencer (rsa32_ctrl):
//   - state_t        : sequencer FSM state encoding
//   - O_ERR_*        : bit positions inside o_err
//   - ERR_W          : width of o_err (3 with operand checking, else 2)
//   - INVALID_RESULT : result word pushed for a rejected operand
// Optional feature macro: RSA32_CTRL_BASE_CHECK_EN
// ---------------------------------------------------------------------------
package rsa32_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_LOAD,
        ST_WAIT_BUSY,
        ST_WAIT_END,
        ST_CAPTURE,
        ST_RELEASE,
        ST_FIN
    } state_t;

    localparam int O_ERR_TIMEOUT  = 0;
    localparam int O_ERR_OVERFLOW = 1;
    localparam int O_ERR_OPERAND  = 2;

`ifdef RSA32_CTRL_BASE_CHECK_EN
    localparam int ERR_W = 3;
`else
    localparam int ERR_W = 2;
`endif

    localparam logic [31:0] INVALID_RESULT = 32'hFFFF_FFFF;

`ifdef RSA32_CTRL_BASE_CHECK_EN
    // The engine only produces meaningful results for base < N with N >= 2.
    function automatic logic operand_invalid(input logic [31:0] base,
                                             input logic [31:0] n);
        return (base >= n) || (n < 32'd2);
    endfunction
`endif

endpackage

// File: rtl/rsa32_ctrl_if.sv
// ---------------------------------------------------------------------------
// rsa32_ctrl_if
// Start/end handshake and operand bus between the sequencer and one rsa32
// engine.
//   eng_start  : level start (sequencer -> engine)
//   eng_base   : base operand
//   eng_exp    : exponent operand
//   eng_n      : modulus operand
//   eng_result : engine result (engine -> sequencer)
//   eng_end    : engine idle/done level (engine -> sequencer)
// modport master : sequencer side; modport slave : engine side.
// ---------------------------------------------------------------------------
interface rsa32_ctrl_if;
    logic        eng_start;
    logic [31:0] eng_base;
    logic [31:0] eng_exp;
    logic [31:0] eng_n;
    logic [31:0] eng_result;
    logic        eng_end;

    modport master (
        output eng_start, eng_base, eng_exp, eng_n,
        input  eng_result, eng_end
    );

    modport slave (
        input  eng_start, eng_base, eng_exp, eng_n,
        output eng_result, eng_end
    );
endinterface

// File: rtl/rsa32_ctrl_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead FIFO.
//   i_clk, i_rstn : clock, asynchronous active-low reset (empties the FIFO)
//   i_push/i_data : write; accepted when not full, or when full and popping
//   i_pop         : read; ignored when empty
//   o_data        : head entry, forced to 0 while empty
//   o_full/o_empty: occupancy flags
// DEPTH must be a power of two (pointers wrap naturally).
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_FULL);
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty;
    // A push into a full FIFO still lands if the head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/rsa32_ctrl.sv
// ---------------------------------------------------------------------------
// rsa32_ctrl
// Batch sequencer for one rsa32 modular-exponentiation engine. Base words are
// queued in an input FIFO, sent one at a time over the engine's level-start /
// end handshake, and results are queued in an output FIFO for the bus side.
//
// Ports:
//   i_clk, i_rstn       : clock, asynchronous active-low reset
//   i_go                : start a batch (ignored while o_busy)
//   i_exp, i_N          : exponent / modulus, sampled on an accepted i_go
//   i_wr_en, i_wr_data  : input FIFO write; o_wr_full when full
//   i_rd_en, o_rd_data  : output FIFO pop / show-ahead head; o_rd_empty
//   o_busy, o_done      : batch in progress / one-cycle completion pulse
//   o_err               : sticky errors (timeout, overflow[, invalid operand])
//   eng                 : engine handshake (rsa32_ctrl_if.master)
//
// Optional feature macro: RSA32_CTRL_BASE_CHECK_EN -- reject base >= N or
// N < 2 without using the engine, push INVALID_RESULT, o_err widens to 3.
// ---------------------------------------------------------------------------
module rsa32_ctrl
    import rsa32_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_go,
    input  logic [31:0]      i_exp,
    input  logic [31:0]      i_N,
    input  logic             i_wr_en,
    input  logic [31:0]      i_wr_data,
    output logic             o_wr_full,
    input  logic             i_rd_en,
    output logic [31:0]      o_rd_data,
    output logic             o_rd_empty,
    output logic             o_busy,
    output logic             o_done,
    output logic [ERR_W-1:0] o_err,
    rsa32_ctrl_if.master     eng
);
    localparam logic [15:0] TMO_LAST = 16'(BUSY_TIMEOUT - 1);

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_start;
    logic [ERR_W-1:0] r_err;
    logic [31:0]      r_base;
    logic [31:0]      r_exp;
    logic [31:0]      r_n;
    logic [15:0]      r_tmo_cnt;

    logic [31:0]      w_in_data;
    logic             w_in_full;
    logic             w_in_empty;
    logic             w_in_pop;
    logic             w_out_full;
    logic             w_out_push;
    logic [31:0]      w_out_data;
    logic             w_tmo_hit;
    logic             w_wr_drop;
`ifdef RSA32_CTRL_BASE_CHECK_EN
    logic             w_invalid;
    assign w_invalid = operand_invalid(w_in_data, r_n);
`endif

    assign w_in_pop  = (r_state == ST_LOAD);
    assign w_tmo_hit = (r_state == ST_WAIT_BUSY) && eng.eng_end && (r_tmo_cnt == TMO_LAST);
    assign w_wr_drop = i_wr_en && w_in_full && !w_in_pop;

    // Result sources: engine result in CAPTURE, zero on a busy timeout, and
    // optionally the invalid-operand marker straight out of LOAD.
    always_comb begin
        w_out_push = 1'b0;
        w_out_data = '0;
        if (r_state == ST_CAPTURE) begin
            w_out_push = 1'b1;
            w_out_data = eng.eng_result;
        end else if (w_tmo_hit) begin
            w_out_push = 1'b1;
        end
`ifdef RSA32_CTRL_BASE_CHECK_EN
        else if ((r_state == ST_LOAD) && w_invalid) begin
            w_out_push = 1'b1;
            w_out_data = INVALID_RESULT;
        end
`endif
    end

    sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_in_fifo (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_push  (i_wr_en),
        .i_data  (i_wr_data),
        .i_pop   (w_in_pop),
        .o_data  (w_in_data),
        .o_full  (w_in_full),
        .o_empty (w_in_empty)
    );

    sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_out_fifo (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_push  (w_out_push),
        .i_data  (w_out_data),
        .i_pop   (i_rd_en),
        .o_data  (o_rd_data),
        .o_full  (w_out_full),
        .o_empty (o_rd_empty)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_start   <= 1'b0;
            r_err     <= '0;
            r_base    <= '0;
            r_exp     <= '0;
            r_n       <= '0;
            r_tmo_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_go) begin
                        r_exp   <= i_exp;
                        r_n     <= i_N;
                        r_err   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_in_empty) begin
                        r_done  <= 1'b1;
                        r_state <= ST_FIN;
                    end else if (!w_out_full) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_base <= w_in_data;
`ifdef RSA32_CTRL_BASE_CHECK_EN
                    if (w_invalid) begin
                        r_err[O_ERR_OPERAND] <= 1'b1;
                        r_state              <= ST_CHECK;
                    end else begin
                        r_start   <= 1'b1;
                        r_tmo_cnt <= '0;
                        r_state   <= ST_WAIT_BUSY;
                    end
`else
                    r_start   <= 1'b1;
                    r_tmo_cnt <= '0;
                    r_state   <= ST_WAIT_BUSY;
`endif
                end
                ST_WAIT_BUSY: begin
                    if (!eng.eng_end) begin
                        r_state <= ST_WAIT_END;
                    end else if (w_tmo_hit) begin
                        r_err[O_ERR_TIMEOUT] <= 1'b1;
                        r_start              <= 1'b0;
                        r_state              <= ST_RELEASE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 16'd1;
                    end
                end
                ST_WAIT_END: begin
                    if (eng.eng_end) r_state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    // Dropping start here gives the engine one low cycle
                    // (RELEASE) to re-arm its level-to-pulse converter.
                    r_start <= 1'b0;
                    r_state <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    r_state <= ST_CHECK;
                end
                ST_FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_start <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
            // Placed after the FSM so an overflow in the go cycle is not lost.
            if (w_wr_drop) r_err[O_ERR_OVERFLOW] <= 1'b1;
        end
    end

    assign o_wr_full     = w_in_full;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_err         = r_err;
    assign eng.eng_start = r_start;
    assign eng.eng_base  = r_base;
    assign eng.eng_exp   = r_exp;
    assign eng.eng_n     = r_n;
endmodule

// File: tb/tb_rsa32_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rsa32_ctrl
// Bench for rsa32_ctrl with a behavioural rsa32 engine responder and a
// queue-based result model. Honours RSA32_CTRL_BASE_CHECK_EN when defined.
// ---------------------------------------------------------------------------
module tb_rsa32_ctrl;
    import rsa32_pkg::*;

    localparam int DEPTH = 8;
    localparam int TMO   = 4;

    logic             clk = 1'b0;
    logic             rstn;
    logic             go = 1'b0;
    logic [31:0]      exp_i = '0;
    logic [31:0]      n_i = '0;
    logic             wr_en = 1'b0;
    logic [31:0]      wr_data = '0;
    logic             wr_full;
    logic             rd_en = 1'b0;
    logic [31:0]      rd_data;
    logic             rd_empty;
    logic             busy;
    logic             done;
    logic [ERR_W-1:0] err;

    rsa32_ctrl_if eng_if();

    rsa32_ctrl #(.DEPTH(DEPTH), .BUSY_TIMEOUT(TMO)) dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_go       (go),
        .i_exp      (exp_i),
        .i_N        (n_i),
        .i_wr_en    (wr_en),
        .i_wr_data  (wr_data),
        .o_wr_full  (wr_full),
        .i_rd_en    (rd_en),
        .o_rd_data  (rd_data),
        .o_rd_empty (rd_empty),
        .o_busy     (busy),
        .o_done     (done),
        .o_err      (err),
        .eng        (eng_if)
    );

    always #5 clk = ~clk;

    int npass = 0;
    int ntot  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        ntot++;
        if (act === want) npass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic logic [31:0] modexp(input logic [31:0] b, input logic [31:0] e,
                                           input logic [31:0] n);
        logic [63:0] r;
        logic [63:0] x;
        if (n == 32'd0) return 32'd0;
        r = 64'd1 % {32'd0, n};
        x = {32'd0, b % n};
        for (int i = 0; i < 32; i++) begin
            if (e[i]) r = (r * x) % {32'd0, n};
            x = (x * x) % {32'd0, n};
        end
        return r[31:0];
    endfunction

    function automatic int bitlen(input logic [31:0] e);
        int k = 0;
        for (int i = 0; i < 32; i++) if (e[i]) k = i + 1;
        return k;
    endfunction

    function automatic bit bad_operand(input logic [31:0] b, input logic [31:0] n);
`ifdef RSA32_CTRL_BASE_CHECK_EN
        return (b >= n) || (n < 32'd2);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_result(input logic [31:0] b, input logic [31:0] e,
                                                 input logic [31:0] n);
        if (bad_operand(b, n)) return 32'hFFFF_FFFF;
        return modexp(b, e, n);
    endfunction

    // ---------------- model state ----------------
    logic [31:0] expq[$];
    logic [31:0] cur_exp = '0;
    logic [31:0] cur_n = '0;
    logic [2:0]  err_model = '0;
    bit          inv_seen = 1'b0;
    int          in_model = 0;
    int          done_cnt = 0;
    int          jobs = 0;
    bit          stuck = 1'b0;

    // ---------------- behavioural engine ----------------
    logic        eng_prev;
    int          eng_cnt;
    logic [31:0] eng_pend;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            eng_if.eng_end    <= 1'b1;
            eng_if.eng_result <= '0;
            eng_prev          <= 1'b0;
            eng_cnt           <= 0;
            eng_pend          <= '0;
        end else begin
            eng_prev <= eng_if.eng_start;
            if (eng_cnt > 0) begin
                if (eng_cnt == 1) begin
                    eng_if.eng_end    <= 1'b1;
                    eng_if.eng_result <= eng_pend;
                end
                eng_cnt <= eng_cnt - 1;
            end else if (!stuck && eng_if.eng_start && !eng_prev) begin
                eng_if.eng_end <= 1'b0;
                eng_cnt        <= bitlen(eng_if.eng_exp) + 3;
                eng_pend       <= modexp(eng_if.eng_base, eng_if.eng_exp, eng_if.eng_n);
                jobs           <= jobs + 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if (rd_en && !rd_empty) begin
                if (expq.size() == 0) chk("unexpected_result", rd_data, 64'hDEAD_0000_0000);
                else chk("result", rd_data, expq.pop_front());
            end
            if (done) done_cnt++;
            if (busy) begin
                chk("eng_exp_hold", eng_if.eng_exp, cur_exp);
                chk("eng_n_hold", eng_if.eng_n, cur_n);
            end else begin
                chk("start_idle_low", eng_if.eng_start, 1'b0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] b, input logic [31:0] e,
                             input logic [31:0] n, input bit accept);
        wr_en   = 1'b1;
        wr_data = b;
        if (accept) begin
            expq.push_back(model_result(b, e, n));
            in_model++;
            if (bad_operand(b, n)) inv_seen = 1'b1;
        end
        tick();
        wr_en = 1'b0;
    endtask

    task automatic start_batch(input logic [31:0] e, input logic [31:0] n);
        exp_i     = e;
        n_i       = n;
        cur_exp   = e;
        cur_n     = n;
        err_model = '0;
        go        = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic wait_done(input int bound, input bit rand_rd);
        int d0;
        int c;
        d0 = done_cnt;
        c  = 0;
        while (done_cnt == d0 && c < bound) begin
            if (rand_rd) rd_en = 1'($urandom % 2);
            tick();
            c++;
        end
        rd_en = 1'b0;
        chk("done_seen", 64'(done_cnt != d0), 64'd1);
        tick(2);
        chk("single_done", 64'(done_cnt - d0), 64'd1);
        chk("busy_after_done", busy, 1'b0);
`ifdef RSA32_CTRL_BASE_CHECK_EN
        if (inv_seen) err_model[2] = 1'b1;
`endif
        inv_seen = 1'b0;
        chk("err_after_batch", err, err_model[ERR_W-1:0]);
        in_model = 0;
    endtask

    task automatic drain();
        rd_en = 1'b1;
        tick(DEPTH + 2);
        rd_en = 1'b0;
        chk("drained_empty", rd_empty, 1'b1);
        chk("model_empty", expq.size(), 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int j0;
        int nvalid;
        int c;
        logic [31:0] n;
        logic [31:0] e;
        logic [31:0] b;

        rstn = 1'b0;
        tick(2);
        // reset state
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, '0);
        chk("rst_rd_empty", rd_empty, 1'b1);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_wr_full", wr_full, 1'b0);
        chk("rst_start", eng_if.eng_start, 1'b0);
        chk("rst_eng_ops", {eng_if.eng_base, eng_if.eng_exp}, 64'd0);
        chk("rst_eng_n", eng_if.eng_n, 32'd0);
        rstn = 1'b1;
        tick(2);

        // pin the reference model
        chk("pin_445", modexp(32'd4, 32'd13, 32'd497), 32'd445);
        chk("pin_5_3_13", modexp(32'd5, 32'd3, 32'd13), 32'd8);
        chk("pin_7_3_13", modexp(32'd7, 32'd3, 32'd13), 32'd5);
        chk("pin_exp0", modexp(32'd7, 32'd0, 32'd11), 32'd1);

        // single word
        push_word(32'd4, 32'd13, 32'd497, 1'b1);
        start_batch(32'd13, 32'd497);
        wait_done(200, 1'b0);
        chk("single_head", rd_data, 32'd445);
        drain();

        // multi word, each must be its own engine job
        j0 = jobs;
        push_word(32'd5, 32'd3, 32'd13, 1'b1);
        push_word(32'd2, 32'd3, 32'd13, 1'b1);
        push_word(32'd7, 32'd3, 32'd13, 1'b1);
        start_batch(32'd3, 32'd13);
        wait_done(300, 1'b0);
        chk("multi_jobs", jobs - j0, 3);
        chk("multi_head", rd_data, 32'd8);
        drain();

        // zero exponent
        push_word(32'd7, 32'd0, 32'd11, 1'b1);
        start_batch(32'd0, 32'd11);
        wait_done(200, 1'b0);
        chk("exp0_head", rd_data, 32'd1);
        drain();

        // back-pressure: overflow on input, stall on full output
        n = $urandom_range(32'hFFFF_0000, 32'd2);
        for (int i = 0; i < 10; i++) begin
            b = $urandom % n;
            push_word(b, 32'd5, n, in_model < DEPTH);
        end
        chk("bp_wr_full", wr_full, 1'b1);
        chk("bp_overflow", err[O_ERR_OVERFLOW], 1'b1);
        j0 = jobs;
        start_batch(32'd5, n);
        tick(30);
        chk("bp_err_cleared", err, '0);
        push_word($urandom % n, 32'd5, n, 1'b1);
        push_word($urandom % n, 32'd5, n, 1'b1);
        tick(250);
        chk("bp_stalled_busy", busy, 1'b1);
        chk("bp_stalled_jobs", jobs - j0, 8);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tick(40);
        chk("bp_resumed_jobs", jobs - j0, 9);
        chk("bp_still_busy", busy, 1'b1);
        rd_en = 1'b1;
        wait_done(400, 1'b0);
        drain();

        // engine stuck idle: timeout produces a zero result
        j0    = jobs;
        stuck = 1'b1;
        push_word(32'd3, 32'd5, 32'd13, 1'b0);
        expq.push_back(32'd0);
        start_batch(32'd5, 32'd13);
        err_model[O_ERR_TIMEOUT] = 1'b1;
        wait_done(100, 1'b0);
        chk("tmo_head", rd_data, 32'd0);
        chk("tmo_no_job", jobs - j0, 0);
        stuck = 1'b0;
        drain();

        // base >= N
        push_word(32'd20, 32'd1, 32'd13, 1'b1);
        start_batch(32'd1, 32'd13);
        wait_done(100, 1'b0);
`ifdef RSA32_CTRL_BASE_CHECK_EN
        chk("basechk_head", rd_data, 32'hFFFF_FFFF);
`else
        chk("basechk_head", rd_data, 32'd7);
`endif
        drain();

        // randomized batches with concurrent random reads
        for (int t = 0; t < 8; t++) begin
            int nw;
            nw     = $urandom_range(6, 1);
            e      = $urandom;
            n      = $urandom_range(32'hFFFF_0000, 32'd2);
            nvalid = 0;
            j0     = jobs;
            for (int k = 0; k < nw; k++) begin
                if (k > 0 && ($urandom % 4) == 0) b = n + $urandom_range(15, 0);
                else b = $urandom % n;
                if (!bad_operand(b, n)) nvalid++;
                push_word(b, e, n, 1'b1);
            end
            start_batch(e, n);
            if ($urandom % 2 == 1) begin
                // lands while the first (valid) word is still in the engine
                tick();
                b = $urandom % n;
                nvalid++;
                push_word(b, e, n, 1'b1);
            end
            wait_done(3000, 1'b1);
            chk("rand_jobs", jobs - j0, nvalid);
            drain();
        end

        // asynchronous reset during WAIT_END
        n = $urandom_range(32'hFFFF_0000, 32'd2);
        for (int i = 0; i < 3; i++) push_word($urandom % n, 32'hFFFF_FFFF, n, 1'b1);
        start_batch(32'hFFFF_FFFF, n);
        c = 0;
        while (eng_if.eng_end !== 1'b0 && c < 20) begin
            tick();
            c++;
        end
        chk("rst_test_engine_busy", eng_if.eng_end, 1'b0);
        tick(3);
        #2 rstn = 1'b0;
        #1;
        chk("midrst_start", eng_if.eng_start, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_rd_empty", rd_empty, 1'b1);
        chk("midrst_err", err, '0);
        expq.delete();
        in_model = 0;
        inv_seen = 1'b0;
        tick(2);
        rstn = 1'b1;
        tick(2);
        // input words were discarded: an empty batch finishes with no results
        start_batch(32'd3, 32'd13);
        wait_done(50, 1'b0);
        chk("post_rst_no_results", rd_empty, 1'b1);
        drain();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule
